// File: rtl/multiplier_control.sv
// Moore control FSM for a 4-bit shift-add multiplier: sequences the bit counter
// and the operand/accumulator datapath, and provides a START/READY/DONE handshake.
module multiplier_control #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          START,
    input  logic          Q0,
    input  logic [CW-1:0] count,
    output logic          READY,
    output logic          LOAD,
    output logic          RESET,
    output logic          ADD,
    output logic          SHIFT,
    output logic          DECREMENT,
    output logic          DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Output vector order: {READY, LOAD, RESET, ADD, SHIFT, DECREMENT, DONE}
    localparam logic [6:0] OUT_IDLE = 7'b100_0000;

    state_t     state_r;
    state_t     next_state_s;
    logic [6:0] outputs_r;

    function automatic logic [6:0] decode_outputs(input state_t st);
        logic [6:0] o;
        case (st)
            S_IDLE:  o = OUT_IDLE;
            S_INIT:  o = 7'b011_0000;
            S_TEST:  o = 7'b000_0000;
            S_ADD:   o = 7'b000_1000;
            S_SHIFT: o = 7'b000_0110;
            S_DONE:  o = 7'b000_0001;
            default: o = OUT_IDLE;
        endcase
        return o;
    endfunction

    // Next-state selection; count and Q0 only matter in TEST
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (START) begin
                    next_state_s = S_INIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_INIT:  next_state_s = S_TEST;
            S_TEST: begin
                if (count == {CW{1'b0}}) begin
                    next_state_s = S_DONE;
                end else if (Q0) begin
                    next_state_s = S_ADD;
                end else begin
                    next_state_s = S_SHIFT;
                end
            end
            S_ADD:   next_state_s = S_SHIFT;
            S_SHIFT: next_state_s = S_TEST;
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Outputs are flopped from the decoded next state, so they track state_r
    // exactly while never depending combinationally on any input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outputs_r <= OUT_IDLE;
        end else begin
            outputs_r <= decode_outputs(next_state_s);
        end
    end

    assign {READY, LOAD, RESET, ADD, SHIFT, DECREMENT, DONE} = outputs_r;

endmodule

// File: tb/tb_multiplier_control.sv
// Self-checking bench for multiplier_control with a behavioural bit counter and
// shift-add datapath attached; expectations go through a scoreboard queue.
module tb_multiplier_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       START;
    logic       Q0;
    logic [2:0] count;
    logic       READY, LOAD, RESET, ADD, SHIFT, DECREMENT, DONE;

    logic [2:0] cnt_r = 3'd0;
    logic [4:0] a_r = 5'd0;
    logic [3:0] q_r = 4'd0;
    logic [3:0] m_r = 4'd0;
    logic [3:0] mult_in = 4'd0;
    logic [3:0] mcand_in = 4'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int product;
        int latency;
        int add_pat;
    } exp_t;
    exp_t sb_q[$];

    multiplier_control #(.CW(3)) dut (
        .clk(clk), .reset(reset), .START(START), .Q0(Q0), .count(count),
        .READY(READY), .LOAD(LOAD), .RESET(RESET), .ADD(ADD), .SHIFT(SHIFT),
        .DECREMENT(DECREMENT), .DONE(DONE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RESET) cnt_r <= 3'd4;
        else if (DECREMENT) cnt_r <= cnt_r - 3'd1;
    end
    assign count = cnt_r;

    always @(posedge clk) begin
        if (LOAD) begin
            a_r <= 5'd0;
            q_r <= mult_in;
            m_r <= mcand_in;
        end else if (ADD) begin
            a_r <= {1'b0, a_r[3:0]} + {1'b0, m_r};
        end else if (SHIFT) begin
            a_r <= {1'b0, a_r[4:1]};
            q_r <= {a_r[0], q_r[3:1]};
        end
    end
    assign Q0 = q_r[0];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int popcount4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic push_exp(input logic [3:0] mcand, input logic [3:0] mult);
        exp_t e;
        e.product = int'(mcand) * int'(mult);
        e.latency = 11 + popcount4(mult);
        e.add_pat = int'(mult);
        sb_q.push_back(e);
    endtask

    // Drive START so that the following posedge is cycle 0
    task automatic start_op(input logic [3:0] mcand, input logic [3:0] mult, input bit hold);
        @(negedge clk);
        check("ready_before_start", int'(READY), 1);
        mcand_in = mcand;
        mult_in  = mult;
        START    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) START = 1'b0;
    endtask

    // Follow one operation from cycle 1 up to DONE and compare with the scoreboard
    task automatic observe_op(input string name, input bit toggle);
        int   done_cyc = 0, n_add = 0, n_shift = 0, n_dec = 0, n_rst = 0, n_load = 0;
        int   load_cyc = 0, overlap = 0, add_pat = 0, cnt_seq = 0, shift_idx = 0;
        int   product = -1, cnt_done = -1;
        bit   prev_add = 1'b0;
        exp_t e;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (toggle && cyc >= 3 && cyc <= 9) START = cyc[0];
            if (toggle && cyc == 10) START = 1'b1;
            if (LOAD) begin n_load++; load_cyc = cyc; end
            if (RESET) n_rst++;
            if (ADD) n_add++;
            if (DECREMENT) n_dec++;
            if (RESET && DECREMENT) overlap++;
            if (SHIFT) begin
                n_shift++;
                if (shift_idx < 4) begin
                    if (prev_add) add_pat |= (1 << shift_idx);
                    cnt_seq |= int'(count) << (3 * shift_idx);
                end
                shift_idx++;
            end
            prev_add = ADD;
            if (DONE) begin
                done_cyc = cyc;
                product  = int'({a_r[3:0], q_r});
                cnt_done = int'(count);
                break;
            end
        end
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_done_cycle"}, done_cyc, e.latency);
            check({name, "_product"}, product, e.product);
            check({name, "_add_pattern"}, add_pat, e.add_pat);
            check({name, "_add_count"}, n_add, e.latency - 11);
        end
        check({name, "_shifts"}, n_shift, 4);
        check({name, "_decrements"}, n_dec, 4);
        check({name, "_resets"}, n_rst, 1);
        check({name, "_loads"}, n_load, 1);
        check({name, "_load_cycle"}, load_cyc, 1);
        check({name, "_rst_dec_overlap"}, overlap, 0);
        check({name, "_count_seq"}, cnt_seq, 4 | (3 << 3) | (2 << 6) | (1 << 9));
        check({name, "_count_at_done"}, cnt_done, 0);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_ready"}, int'(READY), 1);
        check({name, "_done_cleared"}, int'(DONE), 0);
        check({name, "_no_load"}, int'(LOAD), 0);
    endtask

    initial begin
        int found;
        int n_sh;
        int n_done;
        reset = 1'b1;
        START = 1'b0;
        #1;
        check("reset_outputs", int'({READY, LOAD, RESET, ADD, SHIFT, DECREMENT, DONE}), 7'b100_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset while in ADD
        start_op(4'd5, 4'd15, 1'b0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ADD) begin found = 1; break; end
        end
        check("reach_add_state", found, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ready", int'(READY), 1);
        check("async_rst_quiet", int'({ADD, SHIFT, DECREMENT, DONE, LOAD, RESET}), 0);
        @(negedge clk);
        reset = 1'b0;
        push_exp(4'd3, 4'd6);
        start_op(4'd3, 4'd6, 1'b0);
        observe_op("after_reset", 1'b0);
        check_idle("after_reset_idle");

        // Distinct multiplier patterns
        push_exp(4'd9, 4'd0);
        start_op(4'd9, 4'd0, 1'b0);
        observe_op("mult0", 1'b0);
        check_idle("mult0_idle");

        push_exp(4'd15, 4'd15);
        start_op(4'd15, 4'd15, 1'b0);
        observe_op("mult15", 1'b0);
        check_idle("mult15_idle");

        push_exp(4'd3, 4'b1010);
        start_op(4'd3, 4'b1010, 1'b0);
        observe_op("mult10", 1'b0);
        check_idle("mult10_idle");

        for (int i = 0; i < 3; i++) begin
            logic [3:0] mc, ml;
            mc = 4'($urandom_range(0, 15));
            ml = 4'($urandom_range(0, 15));
            push_exp(mc, ml);
            start_op(mc, ml, 1'b0);
            observe_op("rand", 1'b0);
        end

        // START held high: back-to-back with a single READY cycle between
        push_exp(4'd6, 4'd5);
        start_op(4'd6, 4'd5, 1'b1);
        observe_op("hold1", 1'b1);
        @(negedge clk);
        check("hold_gap_ready", int'(READY), 1);
        check("hold_gap_no_load", int'(LOAD), 0);
        push_exp(4'd6, 4'd5);
        observe_op("hold2", 1'b0);
        START = 1'b0;
        check_idle("hold_end_idle");

        // Abort after two shifts, then restart from a full count
        start_op(4'd7, 4'd9, 1'b0);
        n_sh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (SHIFT) n_sh++;
            if (n_sh == 2) break;
        end
        check("abort_two_shifts", n_sh, 2);
        @(negedge clk);
        check("abort_count_2", int'(count), 2);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (DONE || !READY) n_done++;
        end
        check("abort_no_done", n_done, 0);
        push_exp(4'd7, 4'd9);
        start_op(4'd7, 4'd9, 1'b0);
        observe_op("restart", 1'b0);
        check_idle("restart_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
